agc_controller: RTL
===================

AGC_CONTROLLER -- requirements
Module: agc_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, average-power word width.
REQ-002 SHALL have parameter GAIN_WIDTH, default 6, gain code width.
REQ-003 SHALL have parameter GAIN_INIT, default 32, gain code after reset.
REQ-004 SHALL have parameter COARSE_STEP, default 4, large gain step.
REQ-005 SHALL have parameter SETTLE_CYCLES, default 256, post-update blanking.
REQ-006 SHALL have parameter LOCK_COUNT, default 4, in-window measurements needed to lock.
REQ-007 SHALL have parameter ACK_TIMEOUT, default 1024, maximum cycles to wait for gain_ack.
REQ-008 SHALL have port clk input 1, the single clock; all logic on its rising edge.
REQ-009 SHALL have port rst input 1, asynchronous, active-high reset.
REQ-010 SHALL have port avg_power_in input DATA_WIDTH, average power word from the power detector.
REQ-011 SHALL have port avg_power_valid_in input 1, one-cycle qualifier for avg_power_in.
REQ-012 SHALL have port target_power input DATA_WIDTH, setpoint.
REQ-013 SHALL have port hysteresis input DATA_WIDTH, half-width of the lock window.
REQ-014 SHALL have port agc_enable input 1; low forces IDLE.
REQ-015 SHALL have port gain_ack input 1, front-end acknowledge of gain_out.
REQ-016 SHALL have port gain_out output GAIN_WIDTH, gain code to the front end.
REQ-017 SHALL have port gain_update output 1, request; held until acknowledged.
REQ-018 SHALL have port agc_locked output 1, loop in window.
REQ-019 SHALL have port gain_at_limit output 1, a requested step was clipped at 0 or 2^GAIN_WIDTH-1.
REQ-020 SHALL have port ack_error output 1, sticky ack-timeout flag.

Function
REQ-021 SHALL implement states IDLE, MEASURE, UPDATE and SETTLE.
REQ-022 IDLE -> MEASURE when agc_enable=1; any state -> IDLE at the next edge when agc_enable=0.
REQ-023 avg_power_valid_in SHALL be accepted only in MEASURE; it SHALL be ignored in IDLE, UPDATE and SETTLE.
REQ-024 Window: hi = target+hysteresis, computed DATA_WIDTH+1 bits with no wrap; lo = target-hysteresis, saturated at 0.
REQ-025 Coarse thresholds: target<<2 (DATA_WIDTH+2 bits) and target>>2.
REQ-026 Decision on an accepted sample:
- power > target<<2: gain -= COARSE_STEP.
- else power > hi: gain -= 1.
- power < target>>2: gain += COARSE_STEP.
- else power < lo: gain += 1.
- lo <= power <= hi: no change.
REQ-027 Gain arithmetic SHALL saturate to [0, 2^GAIN_WIDTH-1]; gain_at_limit SHALL be set to 1 whenever a step is clipped and cleared on the next unclipped decision.
REQ-028 If the saturated gain equals the current gain, the block SHALL stay in MEASURE and SHALL NOT assert gain_update.
REQ-029 Otherwise, on the edge after acceptance, gain_out SHALL take the new code, gain_update SHALL go to 1 and the state SHALL become UPDATE (decision latency 1 cycle).
REQ-030 In UPDATE, gain_out and gain_update SHALL be stable until gain_ack=1 is sampled; on that edge, gain_update -> 0, the committed gain := gain_out and the state -> SETTLE.
REQ-031 gain_ack=1 sampled in the same cycle gain_update first rises SHALL complete the handshake; gain_ack outside UPDATE SHALL be ignored.
REQ-032 If ACK_TIMEOUT cycles elapse in UPDATE without gain_ack:
- ack_error -> 1;
- gain_update -> 0;
- gain_out reverts to the committed gain;
- state -> MEASURE.
REQ-033 If agc_enable falls during UPDATE, the request SHALL be aborted: gain_update -> 0 and gain_out reverts to the committed gain.
REQ-034 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to MEASURE.
REQ-035 agc_locked SHALL rise after LOCK_COUNT consecutive in-window accepted samples.
REQ-036 agc_locked SHALL clear, together with its counter, on any out-of-window sample or on entry to IDLE.
REQ-037 ack_error SHALL clear only on rst or in IDLE.

Reset
REQ-038 While rst=1, asynchronously:
- gain_out=GAIN_INIT and committed gain=GAIN_INIT;
- gain_update=0, agc_locked=0, gain_at_limit=0, ack_error=0;
- all counters 0; state IDLE.
REQ-039 rst asserted mid-UPDATE or mid-SETTLE SHALL abandon the operation with no glitch on gain_update.

Verification
REQ-040 Settings: target=0x1000, hysteresis=0x100, enable=1; apply power 0x2000 -> gain_out 32->31, gain_update high 1 cycle later; ack after 3 cycles -> gain_update low, then 256 cycles in which valids are ignored.
REQ-041 Power 0x5000 -> gain 32->28; power 0x0300 -> gain +4; step sizes confirmed.
REQ-042 Gain forced to 0 by repeated 0x5000 samples -> further high samples give no gain_update and gain_at_limit=1.
REQ-043 Four consecutive 0x1050 samples -> agc_locked=1 after the 4th; next sample 0x2000 -> agc_locked=0.
REQ-044 No gain_ack for 1024 cycles -> ack_error=1, gain_update=0, gain_out reverts; enable dropped -> ack_error=0.
REQ-045 rst pulse during UPDATE -> gain_out=32 and gain_update=0 immediately (before the next edge); state IDLE.

Source files
------------

// File: rtl/agc_controller.sv
// Automatic gain control loop: windowed power decisions drive a gain code
// over a request/acknowledge handshake, then blank while the front end settles.
// Ports: clk, rst (async, active-high)
//   avg_power_in/avg_power_valid_in : measured power and its qualifier
//   target_power, hysteresis        : setpoint and lock-window half-width
//   agc_enable                      : loop enable, low forces IDLE
//   gain_ack                        : front-end acknowledge
//   gain_out, gain_update           : gain code and pending-change request
//   agc_locked, gain_at_limit       : status flags
//   ack_error                       : sticky acknowledge timeout
module agc_controller #(
  parameter int DATA_WIDTH    = 32,
  parameter int GAIN_WIDTH    = 6,
  parameter int GAIN_INIT     = 32,
  parameter int COARSE_STEP   = 4,
  parameter int SETTLE_CYCLES = 256,
  parameter int LOCK_COUNT    = 4,
  parameter int ACK_TIMEOUT   = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] avg_power_in,
  input  logic                  avg_power_valid_in,
  input  logic [DATA_WIDTH-1:0] target_power,
  input  logic [DATA_WIDTH-1:0] hysteresis,
  input  logic                  agc_enable,
  input  logic                  gain_ack,
  output logic [GAIN_WIDTH-1:0] gain_out,
  output logic                  gain_update,
  output logic                  agc_locked,
  output logic                  gain_at_limit,
  output logic                  ack_error
);

  localparam int TMAX = (SETTLE_CYCLES > ACK_TIMEOUT)
                        ? SETTLE_CYCLES : ACK_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = $clog2(LOCK_COUNT + 1);
  localparam int GMAX = (1 << GAIN_WIDTH) - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_UPDATE,
    S_SETTLE
  } state_t;

  state_t                state_q, state_d;
  logic [GAIN_WIDTH-1:0] gain_q, gain_d;
  logic [GAIN_WIDTH-1:0] commit_q, commit_d;
  logic                  upd_q, upd_d;
  logic                  lock_q, lock_d;
  logic                  lim_q, lim_d;
  logic                  err_q, err_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         timer_q, timer_d;

  logic [DATA_WIDTH:0]   win_hi;
  logic [DATA_WIDTH-1:0] win_lo;
  logic [DATA_WIDTH+1:0] crs_hi;
  logic [DATA_WIDTH-1:0] crs_lo;
  logic                  in_win;
  int                    step;
  int                    g_raw;
  int                    g_sat;
  logic                  clip;
  logic [GAIN_WIDTH-1:0] gain_new;

  // Window and coarse thresholds; the upper ones are widened so they
  // never wrap for large targets.
  always_comb begin
    win_hi = {1'b0, target_power} + {1'b0, hysteresis};
    win_lo = (target_power >= hysteresis)
             ? target_power - hysteresis : '0;
    crs_hi = {2'b00, target_power} << 2;
    crs_lo = target_power >> 2;
  end

  always_comb begin
    step   = 0;
    in_win = 1'b0;
    if ({2'b00, avg_power_in} > crs_hi)
      step = -COARSE_STEP;
    else if ({1'b0, avg_power_in} > win_hi)
      step = -1;
    else if (avg_power_in < crs_lo)
      step = COARSE_STEP;
    else if (avg_power_in < win_lo)
      step = 1;
    else
      in_win = 1'b1;
  end

  always_comb begin
    g_raw = int'(gain_q) + step;
    clip  = (g_raw < 0) || (g_raw > GMAX);
    if (g_raw < 0)
      g_sat = 0;
    else if (g_raw > GMAX)
      g_sat = GMAX;
    else
      g_sat = g_raw;
    gain_new = GAIN_WIDTH'(g_sat);
  end

  always_comb begin
    state_d  = state_q;
    gain_d   = gain_q;
    commit_d = commit_q;
    upd_d    = upd_q;
    lock_d   = lock_q;
    lim_d    = lim_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;

    if (state_q == S_IDLE)
      err_d = 1'b0;

    if (!agc_enable) begin
      // Leaving any state: abort a pending request and drop lock.
      state_d = S_IDLE;
      upd_d   = 1'b0;
      gain_d  = commit_q;
      timer_d = '0;
      lock_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_MEASURE;
        end
        S_MEASURE: begin
          if (avg_power_valid_in) begin
            lim_d = clip;
            if (in_win) begin
              if (cnt_q >= CW'(LOCK_COUNT - 1)) begin
                cnt_d  = CW'(LOCK_COUNT);
                lock_d = 1'b1;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end else begin
              cnt_d  = '0;
              lock_d = 1'b0;
            end
            if (gain_new != gain_q) begin
              gain_d  = gain_new;
              upd_d   = 1'b1;
              timer_d = '0;
              state_d = S_UPDATE;
            end
          end
        end
        S_UPDATE: begin
          if (gain_ack) begin
            upd_d    = 1'b0;
            commit_d = gain_q;
            timer_d  = '0;
            state_d  = S_SETTLE;
          end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            upd_d   = 1'b0;
            gain_d  = commit_q;
            timer_d = '0;
            state_d = S_MEASURE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_SETTLE: begin
          if (timer_q == TW'(SETTLE_CYCLES - 1)) begin
            timer_d = '0;
            state_d = S_MEASURE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gain_q   <= GAIN_WIDTH'(GAIN_INIT);
      commit_q <= GAIN_WIDTH'(GAIN_INIT);
      upd_q    <= 1'b0;
      lock_q   <= 1'b0;
      lim_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      gain_q   <= gain_d;
      commit_q <= commit_d;
      upd_q    <= upd_d;
      lock_q   <= lock_d;
      lim_q    <= lim_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
    end
  end

  assign gain_out      = gain_q;
  assign gain_update   = upd_q;
  assign agc_locked    = lock_q;
  assign gain_at_limit = lim_q;
  assign ack_error     = err_q;

endmodule
